mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 42 ++++
 rtl/mem_arbiter_lat.sv | 30 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds FSM state encodings, port identifiers and read/write polarity.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned MEM_LAT_DEF = 2;

  // Wide enough for MEM_LAT up to 15.
  localparam int unsigned CNT_W = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Round-robin pick: on a tie the port that was not served last wins.
  function automatic port_t pick_port(input logic f_req, input logic d_req,
                                      input port_t last_gnt);
    port_t p;
    if (f_req && d_req) begin
      if (last_gnt == PORT_D) p = PORT_F;
      else                    p = PORT_D;
    end else if (d_req) begin
      p = PORT_D;
    end else begin
      p = PORT_F;
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_arbiter_lat.sv
// Memory latency counter: loadable down-counter with a zero flag,
// used to time the WAIT phase of a memory transaction.
module mem_lat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single fixed-latency memory port.
// One transaction in flight: IDLE -> ISSUE -> WAIT x MEM_LAT -> DONE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              read_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Counter is loaded with MEM_LAT-1 so that it reads zero on the last WAIT cycle.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t state;
  state_t next_state;
  port_t  last_gnt;
  port_t  owner;
  port_t  winner;
  logic   accept;
  logic   finish;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  assign winner = pick_port(f_req, d_req, last_gnt);
  assign accept = (state == ST_IDLE) && (f_req || d_req);
  assign finish = (state == ST_WAIT) && cnt_zero;
  assign busy   = (state != ST_IDLE);

  mem_lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (f_req || d_req) next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        next_state = ST_WAIT;
        cnt_load   = 1'b1;
      end
      ST_WAIT: begin
        if (cnt_zero) next_state = ST_DONE;
        else          cnt_dec    = 1'b1;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Arbitration and transaction latch: only sampled on the IDLE accept edge,
  // so requests changing later cannot disturb an in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt   <= PORT_D;
      owner      <= PORT_F;
      read_write <= RW_READ;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else if (accept) begin
      last_gnt <= winner;
      owner    <= winner;
      if (winner == PORT_F) begin
        read_write <= RW_READ;
        mem_addr   <= f_addr;
      end else begin
        read_write <= d_rw;
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
      end
    end
  end

  // Pulses are registered from the transition into ISSUE / DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en <= 1'b0;
      f_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      f_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      mem_en <= accept;
      f_gnt  <= accept && (winner == PORT_F);
      d_gnt  <= accept && (winner == PORT_D);
      f_done <= finish && (owner == PORT_F);
      d_done <= finish && (owner == PORT_D);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_rdata <= '0;
      d_rdata <= '0;
    end else if (finish && (read_write == RW_READ)) begin
      if (owner == PORT_F) f_rdata <= mem_rdata;
      else                 d_rdata <= mem_rdata;
    end
  end

endmodule
